// File: rtl/ppu_pkg.sv
//------------------------------------------------------------------------------
// Module   : ppu_pkg
// Purpose  : Shared constants, types and the palette address mirroring helper
//            for the PPU pixel output path.
// Contents : VISIBLE_W, FIRST_VISIBLE_LINE, LAST_VISIBLE_LINE,
//            PRERENDER_LINE, LEFT_CLIP_W, pal_idx_t, pal_mirror()
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ppu_pkg;

  // Sized to match the 10-bit dot/line counters they are compared against.
  localparam logic [9:0] VISIBLE_W          = 10'd256;
  localparam logic [9:0] FIRST_VISIBLE_LINE = 10'd1;
  localparam logic [9:0] LAST_VISIBLE_LINE  = 10'd240;
  localparam logic [9:0] PRERENDER_LINE     = 10'd0;
  localparam logic [9:0] LEFT_CLIP_W        = 10'd8;

  typedef logic [4:0] pal_idx_t;

  // Sprite palette entry 0 of each group ($3F10/14/18/1C) aliases the
  // matching background entry ($3F00/04/08/0C).
  function automatic pal_idx_t pal_mirror(input pal_idx_t a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppu_palette_ram.sv
//------------------------------------------------------------------------------
// Module   : ppu_palette_ram
// Purpose  : 32x6 palette storage with one write port and two registered,
//            mirrored read ports (pixel lookup and CPU read-back).
// Ports    : clk, reset      - clock, async active-high reset
//            i_we/i_waddr/i_wdata - CPU write port
//            i_lk_addr -> o_lk_data   - lookup read, 1 clock latency
//            i_cpu_addr -> o_cpu_data - CPU read, 1 clock latency
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppu_palette_ram import ppu_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_we,
  input  pal_idx_t   i_waddr,
  input  logic [5:0] i_wdata,
  input  pal_idx_t   i_lk_addr,
  output logic [5:0] o_lk_data,
  input  pal_idx_t   i_cpu_addr,
  output logic [5:0] o_cpu_data
);

  logic [5:0] r_mem [32];

  // Reads sample r_mem before this edge's write lands, so a same-cycle
  // write/read of one address returns the old entry on both ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 6'h00;
      end
      o_lk_data  <= 6'h00;
      o_cpu_data <= 6'h00;
    end else begin
      if (i_we) begin
        r_mem[pal_mirror(i_waddr)] <= i_wdata;
      end
      o_lk_data  <= r_mem[pal_mirror(i_lk_addr)];
      o_cpu_data <= r_mem[pal_mirror(i_cpu_addr)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ppu_pixel_mux.sv
//------------------------------------------------------------------------------
// Module   : ppu_pixel_mux
// Purpose  : Background/sprite priority multiplexer, palette lookup and
//            sprite-0 hit detection for the PPU pixel output.
// Ports    : clk, reset - pixel clock, async active-high reset
//            bg_pixel, spr_pixel, spr_priority, spr_is_zero - pixel sources
//            x_idx, scanline - current dot/line
//            show_bg, show_spr, show_bg_left, show_spr_left - mask enables
//            pal_we, pal_addr, pal_wdata, pal_rdata - CPU palette access
//            color, color_valid - 2-clock pipelined output colour
//            sprite0_hit - sticky sprite-0 hit flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppu_pixel_mux import ppu_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bg_pixel,
  input  logic [3:0] spr_pixel,
  input  logic       spr_priority,
  input  logic       spr_is_zero,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       show_bg,
  input  logic       show_spr,
  input  logic       show_bg_left,
  input  logic       show_spr_left,
  input  logic       pal_we,
  input  logic [4:0] pal_addr,
  input  logic [7:0] pal_wdata,
  output logic [7:0] pal_rdata,
  output logic [5:0] color,
  output logic       color_valid,
  output logic       sprite0_hit
);

  logic     w_visible;
  logic     w_in_left;
  logic     w_bg_opaque;
  logic     w_spr_opaque;
  pal_idx_t w_idx;
  logic     w_hit_set;
  logic     w_hit_clr;
  logic     w_unused_wdata;

  pal_idx_t r_idx;
  logic     r_vis;
  logic     r_color_valid;
  logic     r_sprite0_hit;
  logic [5:0] w_cpu_data;

  // Palette entries are 6 bits wide; the top two write bits are dropped.
  assign w_unused_wdata = ^pal_wdata[7:6];

  assign w_visible = (x_idx < VISIBLE_W) &&
                     (scanline >= FIRST_VISIBLE_LINE) &&
                     (scanline <= LAST_VISIBLE_LINE);
  assign w_in_left = (x_idx < LEFT_CLIP_W);

  assign w_bg_opaque  = show_bg  && (bg_pixel[1:0]  != 2'b00) &&
                        !(w_in_left && !show_bg_left);
  assign w_spr_opaque = show_spr && (spr_pixel[1:0] != 2'b00) &&
                        !(w_in_left && !show_spr_left);

  always_comb begin
    w_idx = 5'h00;
    if (w_spr_opaque && (!w_bg_opaque || !spr_priority)) begin
      w_idx = {1'b1, spr_pixel};
    end else if (w_bg_opaque) begin
      w_idx = {1'b0, bg_pixel};
    end
  end

  assign w_hit_set = w_visible && spr_is_zero && w_bg_opaque && w_spr_opaque &&
                     (x_idx != 10'd255);
  assign w_hit_clr = (scanline == PRERENDER_LINE) && (x_idx == 10'd1);

  // Stage 1. Invisible dots carry index 0 so stage 2 naturally shows the
  // backdrop colour whenever color_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= 5'h00;
      r_vis         <= 1'b0;
      r_color_valid <= 1'b0;
      r_sprite0_hit <= 1'b0;
    end else begin
      r_idx         <= w_visible ? w_idx : 5'h00;
      r_vis         <= w_visible;
      r_color_valid <= r_vis;
      if (w_hit_clr) begin
        r_sprite0_hit <= 1'b0;
      end else if (w_hit_set) begin
        r_sprite0_hit <= 1'b1;
      end
    end
  end

  // Stage 2 colour register lives in the RAM's lookup read port.
  ppu_palette_ram u_palette (
    .clk        (clk),
    .reset      (reset),
    .i_we       (pal_we),
    .i_waddr    (pal_addr),
    .i_wdata    (pal_wdata[5:0]),
    .i_lk_addr  (r_idx),
    .o_lk_data  (color),
    .i_cpu_addr (pal_addr),
    .o_cpu_data (w_cpu_data)
  );

  assign pal_rdata   = {2'b00, w_cpu_data};
  assign color_valid = r_color_valid;
  assign sprite0_hit = r_sprite0_hit;

endmodule

`default_nettype wire
